// File: rtl/inv_bank_filt_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_bank_filt_if : channel, configuration and event bundle           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface inv_bank_filt_if #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
);
  logic [NCH-1:0]    i;
  logic [NCH-1:0]    o;
  logic              cfg_load;
  logic [NCH-1:0]    cfg_pol;
  logic [FILT_W-1:0] cfg_thr;
  logic              cfg_ack;
  logic [NCH-1:0]    evt_clr;
  logic [NCH-1:0]    evt;
  logic              irq;

  modport master (
    output i, cfg_load, cfg_pol, cfg_thr, evt_clr,
    input  o, cfg_ack, evt, irq
  );

  modport slave (
    input  i, cfg_load, cfg_pol, cfg_thr, evt_clr,
    output o, cfg_ack, evt, irq
  );
endinterface
`default_nettype wire

// File: rtl/inv_bank_filt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_bank_filt : per-channel sync, deglitch filter, polarity, events  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inv_bank_filt #(
  parameter int             NCH     = 4,
  parameter int             FILT_W  = 4,
  parameter int             THR_RST = 3,
  parameter logic [NCH-1:0] POL_RST = '1
) (
  input  wire logic         CLK,
  input  wire logic         RSTB,
  input  wire logic         CELV,
  input  wire logic         CELG,
  input  wire logic         SUB,
  inv_bank_filt_if.slave    bus
);

  localparam logic [FILT_W-1:0] c_thr_rst = THR_RST[FILT_W-1:0];

  logic [NCH-1:0]    r_s1;
  logic [NCH-1:0]    r_s2;
  logic [NCH-1:0]    r_f;
  logic [NCH-1:0]    r_pol;
  logic [NCH-1:0]    r_evt;
  logic [FILT_W-1:0] r_thr;
  logic              r_ack;
  logic [NCH-1:0]    w_flip;
  logic [FILT_W:0]   w_thr_eff;

  // Supply pins carry no logic; folded here only so they are not dangling.
  wire w_unused_pins = CELV ^ CELG ^ SUB;

  assign w_thr_eff = (r_thr == '0) ? (FILT_W+1)'(1) : {1'b0, r_thr};

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [FILT_W-1:0] r_cnt;
      logic [FILT_W:0]   w_cnt_inc;

      assign w_cnt_inc = {1'b0, r_cnt} + (FILT_W+1)'(1);
      // A configuration write freezes the filtered level for that edge.
      assign w_flip[k] = (r_s2[k] != r_f[k]) && (w_cnt_inc >= w_thr_eff) && !bus.cfg_load;

      always_ff @(posedge CLK) begin
        if (!RSTB) begin
          r_cnt <= '0;
        end else if (bus.cfg_load || (r_s2[k] == r_f[k]) || w_flip[k]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc[FILT_W-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_f   <= '0;
      r_evt <= '0;
      r_ack <= 1'b0;
      r_pol <= POL_RST;
      r_thr <= c_thr_rst;
    end else begin
      r_s1  <= bus.i;
      r_s2  <= r_s1;
      r_f   <= r_f ^ w_flip;
      // Set beats clear when both land on the same edge.
      r_evt <= (r_evt & ~bus.evt_clr) | w_flip;
      r_ack <= bus.cfg_load;
      if (bus.cfg_load) begin
        r_pol <= bus.cfg_pol;
        r_thr <= bus.cfg_thr;
      end
    end
  end

  assign bus.o       = r_f ^ r_pol;
  assign bus.evt     = r_evt;
  assign bus.irq     = |r_evt;
  assign bus.cfg_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_inv_bank_filt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inv_bank_filt : directed + random checks against a timing model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inv_bank_filt;
  localparam int NCH = 4;
  localparam int FW  = 4;

  logic CLK  = 1'b0;
  logic RSTB = 1'b0;
  logic CELV = 1'b1;
  logic CELG = 1'b0;
  logic SUB  = 1'b0;

  always #5 CLK = ~CLK;

  inv_bank_filt_if #(.NCH(NCH), .FILT_W(FW)) bus ();

  inv_bank_filt #(
    .NCH(NCH), .FILT_W(FW), .THR_RST(3), .POL_RST(4'hF)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: a channel flips once s2 has disagreed with f for max(thr,1)
  // consecutive edges since the last agreement, flip, reset or config write.
  logic [NCH-1:0] m_s1, m_s2, m_f, m_pol, m_evt;
  int             m_thr;
  logic           m_ack;
  int             last_ok [NCH];
  int             n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NCH-1:0] flip;
    int te;
    n++;
    if (!RSTB) begin
      m_s1 = '0; m_s2 = '0; m_f = '0; m_evt = '0; m_ack = 1'b0;
      m_pol = 4'hF; m_thr = 3;
      for (int k = 0; k < NCH; k++) last_ok[k] = n;
    end else begin
      te   = (m_thr == 0) ? 1 : m_thr;
      flip = '0;
      for (int k = 0; k < NCH; k++) begin
        if (bus.cfg_load || (m_s2[k] == m_f[k])) last_ok[k] = n;
        else if (n - last_ok[k] >= te) begin
          flip[k]    = 1'b1;
          last_ok[k] = n;
        end
      end
      m_evt = (m_evt & ~bus.evt_clr) | flip;
      m_f   = m_f ^ flip;
      m_s2  = m_s1;
      m_s1  = bus.i;
      m_ack = bus.cfg_load;
      if (bus.cfg_load) begin
        m_pol = bus.cfg_pol;
        m_thr = int'(bus.cfg_thr);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("o",       32'(bus.o),       32'(m_f ^ m_pol));
    chk("evt",     32'(bus.evt),     32'(m_evt));
    chk("irq",     32'(bus.irq),     32'(|m_evt));
    chk("cfg_ack", 32'(bus.cfg_ack), 32'(m_ack));
  endtask

  // Edges until o[k] changes, bounded; -1 if it never does.
  task automatic measure(input int k, output int lat);
    logic p;
    p   = bus.o[k];
    lat = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (lat < 0 && bus.o[k] !== p) lat = e;
    end
  endtask

  initial begin
    int lat;
    bus.i = '0; bus.cfg_load = 1'b0; bus.cfg_pol = '0; bus.cfg_thr = '0; bus.evt_clr = '0;
    m_s1 = '0; m_s2 = '0; m_f = '0; m_evt = '0; m_pol = 4'hF; m_thr = 3; m_ack = 1'b0;
    for (int k = 0; k < NCH; k++) last_ok[k] = 0;

    // Reset state
    tick(); tick();
    RSTB = 1'b1;
    tick();
    chk("rst_o",   32'(bus.o),       32'hF);
    chk("rst_irq", 32'(bus.irq),     32'h0);
    chk("rst_ack", 32'(bus.cfg_ack), 32'h0);

    // Rising i[0] with thr=3: 5 edges to o[0]
    bus.i[0] = 1'b1;
    measure(0, lat);
    chk("lat_thr3",  32'(lat),        32'd5);
    chk("evt0_set",  32'(bus.evt[0]), 32'h1);
    chk("irq_set",   32'(bus.irq),    32'h1);

    // Two-cycle glitch on i[1] is swallowed
    bus.i[1] = 1'b1;
    tick(); tick();
    bus.i[1] = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("glitch_o1",   32'(bus.o[1]),   32'h1);
    chk("glitch_evt1", 32'(bus.evt[1]), 32'h0);

    // evt_clr coinciding with a flip loses to the set
    bus.i[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    bus.evt_clr = 4'b0001;
    tick();
    chk("set_wins_o0",  32'(bus.o[0]),   32'h1);
    chk("set_wins_evt", 32'(bus.evt[0]), 32'h1);
    tick();
    chk("clr_evt0",     32'(bus.evt[0]), 32'h0);
    bus.evt_clr = '0;

    // Config write: pol=0101, thr=0
    bus.cfg_load = 1'b1; bus.cfg_pol = 4'b0101; bus.cfg_thr = '0;
    tick();
    chk("ack_pulse", 32'(bus.cfg_ack), 32'h1);
    chk("pol_o",     32'(bus.o),       32'(4'b0101));
    bus.cfg_load = 1'b0;
    tick();
    chk("ack_drop",  32'(bus.cfg_ack), 32'h0);
    bus.i[2] = 1'b1;
    measure(2, lat);
    chk("lat_thr0",  32'(lat),         32'd3);

    // Back-to-back loads then reset during a count with a load pending
    bus.cfg_load = 1'b1; bus.cfg_thr = 4'd6; bus.cfg_pol = 4'b0011;
    tick(); tick();
    chk("ack_b2b", 32'(bus.cfg_ack), 32'h1);
    bus.cfg_load = 1'b0;
    bus.i[3] = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    RSTB = 1'b0; bus.cfg_load = 1'b1; bus.cfg_pol = 4'b0000; bus.evt_clr = 4'hF;
    tick();
    chk("rst_ovr_ack", 32'(bus.cfg_ack), 32'h0);
    chk("rst_ovr_o",   32'(bus.o),       32'hF);
    chk("rst_ovr_evt", 32'(bus.evt),     32'h0);
    RSTB = 1'b1; bus.cfg_load = 1'b0; bus.evt_clr = '0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 3) == 0) bus.i[k] = ~bus.i[k];
      bus.cfg_load = ($urandom_range(0, 14) == 0);
      bus.cfg_pol  = NCH'($urandom);
      bus.cfg_thr  = FW'($urandom_range(0, 4));
      for (int k = 0; k < NCH; k++) bus.evt_clr[k] = ($urandom_range(0, 3) == 0);
      RSTB = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
